// File: rtl/mem_copier_if.sv
// mem_copier_if: word-wide memory bus between the copier (master) and memory (slave).
interface mem_copier_if;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic [3:0]  byte_enable;
   logic        write_req;
   logic        read_req;
   logic [31:0] read_data;
   logic        read_data_valid;
   modport master (
      input  ready, read_data, read_data_valid,
      output addr, write_data, byte_enable, write_req, read_req
   );
   modport slave (
      output ready, read_data, read_data_valid,
      input  addr, write_data, byte_enable, write_req, read_req
   );
endinterface

// File: rtl/mem_copier.sv
// mem_copier: copies word_count words from src_addr to dst_addr, one read then one write per word,
// aborting with error when a read return does not arrive within TIMEOUT_CYCLES.
module mem_copier #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [31:0]  src_addr,
   input  logic [31:0]  dst_addr,
   input  logic [15:0]  word_count,
   output logic         busy,
   output logic         done,
   output logic         error,
   mem_copier_if.master bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   typedef enum logic [2:0] {IDLE, READ_REQ, READ_WAIT, WRITE_REQ, FINISH} state_t;
   state_t      state;
   logic [31:0] src;
   logic [31:0] dst;
   logic [15:0] remaining;
   logic [TW-1:0] timer;
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state           <= IDLE;
         src             <= '0;
         dst             <= '0;
         remaining       <= '0;
         timer           <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         error           <= 1'b0;
         bus.addr        <= '0;
         bus.write_data  <= '0;
         bus.byte_enable <= '0;
         bus.write_req   <= 1'b0;
         bus.read_req    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               busy      <= 1'b1;
               src       <= src_addr;
               dst       <= dst_addr;
               remaining <= word_count;
               if (word_count == 16'd0) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end else begin
                  state        <= READ_REQ;
                  bus.read_req <= 1'b1;
                  bus.addr     <= src_addr;
               end
            end
            READ_REQ: if (bus.ready) begin
               state        <= READ_WAIT;
               bus.read_req <= 1'b0;
               bus.addr     <= '0;
               timer        <= '0;
            end
            // the returned word goes straight into the write-data register for the next request
            READ_WAIT: if (bus.read_data_valid) begin
               state           <= WRITE_REQ;
               bus.write_req   <= 1'b1;
               bus.addr        <= dst;
               bus.write_data  <= bus.read_data;
               bus.byte_enable <= 4'hf;
            end else if (timer == T_LAST) begin
               state <= FINISH;
               done  <= 1'b1;
               error <= 1'b1;
            end else begin
               timer <= timer + TW'(1);
            end
            WRITE_REQ: if (bus.ready) begin
               bus.write_req   <= 1'b0;
               bus.write_data  <= '0;
               bus.byte_enable <= '0;
               src             <= src + 32'd4;
               dst             <= dst + 32'd4;
               remaining       <= remaining - 16'd1;
               if (remaining == 16'd1) begin
                  state    <= FINISH;
                  done     <= 1'b1;
                  bus.addr <= '0;
               end else begin
                  state        <= READ_REQ;
                  bus.read_req <= 1'b1;
                  bus.addr     <= src + 32'd4;
               end
            end
            FINISH: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               error <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_copier.sv
// tb_mem_copier: randomized memory slave plus a transaction-level model of the copy,
// checked against the DUT on every falling edge.
module tb_mem_copier;
   localparam int TO = 255;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] word_count = '0;
   logic        busy, done, error;
   mem_copier_if bus();
   mem_copier #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .word_count(word_count), .busy(busy), .done(done), .error(error), .bus(bus)
   );
   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEADBEEF;
   endfunction

   // slave knobs: ready_mode 0 = random percent, 1 = always, 2 = low for 5 cycles per request
   int ready_mode = 1, ready_pct = 100, lat_min = 1, lat_max = 1;
   bit no_return = 0, stray_en = 0;
   int ret_timer = 0, held = 0;
   logic [31:0] ret_data = '0;

   // model of the copy as a list of pending reads plus the word in flight
   bit m_active = 0, m_done_due = 0, m_err_due = 0, m_out = 0, m_have = 0;
   logic [31:0] m_reads[$];
   logic [31:0] m_dst = '0, m_wd = '0;
   int m_rem = 0, m_wait = 0;

   logic [31:0] r_log[$], w_addr_log[$], w_data_log[$];
   int start_cyc = 0, done_cyc = 0, dones = 0, busy_cnt = 0, read_acc_cyc = 0;
   bit last_err = 0;
   bit p_hold = 0, p_r = 0, p_w = 0;
   logic [31:0] p_a = '0, p_d = '0;
   logic [3:0]  p_be = '0;

   always @(negedge clk) begin
      bit v, rdy, dn, er;
      logic [31:0] rd, ea;
      cyc++;
      chk("busy", busy, m_active);
      chk("done", done, m_done_due);
      chk("error", error, m_done_due && m_err_due);
      chk("req_exclusive", bus.read_req && bus.write_req, 0);
      if (p_hold) begin
         chk("hold_rreq", bus.read_req, p_r);
         chk("hold_wreq", bus.write_req, p_w);
         chk("hold_addr", bus.addr, p_a);
         chk("hold_wdata", bus.write_data, p_d);
         chk("hold_be", bus.byte_enable, p_be);
      end
      if (bus.read_req) begin
         chk("rd_allowed", m_active && m_reads.size() > 0 && !m_out && !m_have && !m_done_due, 1);
         if (m_reads.size() > 0) chk("rd_addr", bus.addr, m_reads[0]);
         chk("rd_wdata_zero", bus.write_data, 0);
         chk("rd_be_zero", bus.byte_enable, 0);
      end else if (bus.write_req) begin
         chk("wr_allowed", m_have && !m_out, 1);
         chk("wr_addr", bus.addr, m_dst);
         chk("wr_data", bus.write_data, m_wd);
         chk("wr_be", bus.byte_enable, 4'hf);
      end else begin
         chk("idle_addr", bus.addr, 0);
         chk("idle_wdata", bus.write_data, 0);
         chk("idle_be", bus.byte_enable, 0);
      end
      if (busy) busy_cnt++;
      if (done) begin dones++; done_cyc = cyc; last_err = error; end
      // memory slave for this cycle
      rdy = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? (held >= 5) : ($urandom_range(99) < ready_pct);
      v = 0;
      rd = $urandom;
      if (ret_timer > 0) begin
         ret_timer--;
         if (ret_timer == 0) begin v = 1; rd = ret_data; end
      end else if (stray_en && !m_out && $urandom_range(3) == 0) v = 1;
      bus.ready = rdy;
      bus.read_data_valid = v;
      bus.read_data = rd;
      held = ((bus.read_req || bus.write_req) && !rdy) ? held + 1 : 0;
      p_hold = reset_n && (bus.read_req || bus.write_req) && !rdy;
      p_r = bus.read_req; p_w = bus.write_req; p_a = bus.addr; p_d = bus.write_data; p_be = bus.byte_enable;
      // model advance across the coming rising edge
      if (!reset_n) begin
         m_active = 0; m_done_due = 0; m_err_due = 0; m_out = 0; m_have = 0;
         m_reads.delete();
      end else begin
         dn = 0;
         er = 0;
         if (m_done_due) m_active = 0;
         else if (!m_active) begin
            if (start) begin
               m_active = 1;
               start_cyc = cyc;
               m_dst = dst_addr;
               m_rem = word_count;
               for (int i = 0; i < int'(word_count); i++) m_reads.push_back(src_addr + 32'(4 * i));
               if (word_count == 0) dn = 1;
            end
         end else if (bus.read_req && rdy) begin
            ea = (m_reads.size() > 0) ? m_reads.pop_front() : bus.addr;
            r_log.push_back(bus.addr);
            m_out = 1;
            m_wait = 0;
            read_acc_cyc = cyc;
            if (!no_return) begin
               ret_timer = $urandom_range(lat_max, lat_min);
               ret_data = mem_word(ea);
            end
         end else if (m_out) begin
            if (v) begin m_out = 0; m_have = 1; m_wd = rd; end
            else begin
               m_wait++;
               if (m_wait == TO) begin m_out = 0; m_reads.delete(); dn = 1; er = 1; end
            end
         end else if (bus.write_req && rdy) begin
            w_addr_log.push_back(bus.addr);
            w_data_log.push_back(bus.write_data);
            m_have = 0;
            m_dst = m_dst + 32'd4;
            m_rem--;
            if (m_rem == 0) dn = 1;
         end
         m_done_due = dn;
         m_err_due = er;
      end
   end

   task automatic clear_logs();
      r_log.delete();
      w_addr_log.delete();
      w_data_log.delete();
      busy_cnt = 0;
   endtask

   task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, input bit spam);
      int d0;
      d0 = dones;
      @(posedge clk); #1;
      start = 1; src_addr = s; dst_addr = d; word_count = n;
      @(posedge clk); #1;
      start = 0;
      for (int k = 0; k < 2000 && dones == d0; k++) begin
         if (spam && m_active && $urandom_range(2) == 0) begin
            start = 1; src_addr = $urandom; dst_addr = $urandom; word_count = 16'($urandom);
         end else start = 0;
         @(posedge clk); #1;
      end
      start = 0;
      chk("copy_completes", dones != d0, 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rreq", bus.read_req, 0);
      chk("rst_wreq", bus.write_req, 0);
      chk("rst_addr", bus.addr, 0);
      reset_n = 1;

      clear_logs();
      do_copy(32'h1000_0000, 32'h2000_0000, 16'd3, 0);
      chk("basic_nreads", r_log.size(), 3);
      chk("basic_nwrites", w_addr_log.size(), 3);
      chk("basic_waddr0", w_addr_log[0], 32'h2000_0000);
      chk("basic_waddr1", w_addr_log[1], 32'h2000_0004);
      chk("basic_waddr2", w_addr_log[2], 32'h2000_0008);
      chk("basic_wdata0", w_data_log[0], 32'hCEAD_BEEF);
      chk("basic_wdata1", w_data_log[1], 32'hCEAD_BEEB);
      chk("basic_wdata2", w_data_log[2], 32'hCEAD_BEE7);
      chk("basic_latency", done_cyc - start_cyc, 10);
      chk("basic_err", last_err, 0);

      clear_logs();
      do_copy(32'h0000_0040, 32'h0000_0080, 16'd0, 0);
      chk("zero_latency", done_cyc - start_cyc, 1);
      chk("zero_busy_cycles", busy_cnt, 1);
      chk("zero_no_bus", r_log.size() + w_addr_log.size(), 0);
      chk("zero_err", last_err, 0);

      ready_mode = 2; lat_max = 3;
      clear_logs();
      do_copy(32'h0000_0300, 32'h0000_8000, 16'd3, 0);
      chk("hold_nreads", r_log.size(), 3);
      chk("hold_nwrites", w_addr_log.size(), 3);
      chk("hold_wdata2", w_data_log[2], 32'hDEAD_BDE7);

      ready_mode = 1; lat_max = 1; no_return = 1;
      clear_logs();
      do_copy(32'h0000_4000, 32'h0000_5000, 16'd2, 0);
      chk("timeout_err", last_err, 1);
      chk("timeout_wait", done_cyc - read_acc_cyc, TO + 1);
      chk("timeout_nwrites", w_addr_log.size(), 0);
      no_return = 0;
      clear_logs();
      do_copy(32'h0000_4000, 32'h0000_5000, 16'd2, 0);
      chk("after_timeout_err", last_err, 0);
      chk("after_timeout_nwrites", w_addr_log.size(), 2);

      ready_mode = 0; ready_pct = 60; lat_max = 3; stray_en = 1;
      clear_logs();
      do_copy(32'hFFFF_FFFC, 32'h0000_0100, 16'd2, 1);
      chk("wrap_raddr0", r_log[0], 32'hFFFF_FFFC);
      chk("wrap_raddr1", r_log[1], 32'h0000_0000);
      chk("wrap_wdata0", w_data_log[0], 32'h2152_4113);
      chk("wrap_wdata1", w_data_log[1], 32'hDEAD_BEEF);
      chk("wrap_waddr1", w_addr_log[1], 32'h0000_0104);

      ready_mode = 1; lat_min = 4; lat_max = 4; stray_en = 0;
      clear_logs();
      @(posedge clk); #1;
      start = 1; src_addr = 32'h600; dst_addr = 32'h700; word_count = 16'd4;
      @(posedge clk); #1;
      start = 0;
      for (int k = 0; k < 200 && !(w_addr_log.size() == 1 && m_out); k++) begin
         @(posedge clk); #1;
      end
      chk("rst_mid_reached", w_addr_log.size() == 1 && m_out, 1);
      d0 = dones;
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      chk("rst_mid_rreq", bus.read_req, 0);
      chk("rst_mid_addr", bus.addr, 0);
      repeat (8) @(posedge clk);
      #1;
      chk("rst_mid_no_done", dones, d0);
      chk("rst_mid_late_ignored", busy, 0);
      lat_min = 1; lat_max = 2;
      clear_logs();
      do_copy(32'h600, 32'h700, 16'd4, 0);
      chk("rst_recover_nwrites", w_addr_log.size(), 4);
      chk("rst_recover_err", last_err, 0);

      ready_mode = 0; stray_en = 1;
      for (int t = 0; t < 10; t++) begin
         ready_pct = $urandom_range(100, 40);
         lat_max = $urandom_range(4, 1);
         clear_logs();
         do_copy({$urandom_range(32'hFFFF_FFFF, 0)} & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                 16'($urandom_range(6, 0)), 1);
         chk("rand_err", last_err, 0);
         chk("rand_balance", r_log.size(), w_addr_log.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
      $fatal(1);
   end
endmodule
